iguana_hyper_init_seq: RTL and testbench

Boot-time configuration sequencer for the HyperBus register-bus slave window on Iguana (base `0x1_0000_0000`, 2 chips × 1 PHY). After reset it owns the HyperBus config register port and issues a parameterised table of register writes, with inter-write settle gaps and bounded retries on error. It then hands the port to the Cheshire external register-bus master (`RegOutHyperBusIdx` = 0) as a transparent pass-through. It sits between the Cheshire reg-out demux port 0 and the HyperBus config slave.

---
 rtl/iguana_hyper_init_seq.sv | 195 +++++++++++++++++++
 tb/tb_iguana_hyper_init_seq.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iguana_hyper_init_seq.sv
// iguana_hyper_init_seq: boot-time configuration sequencer for the HyperBus
// config register window. After reset it writes a table of registers through
// the master port, with settle gaps and bounded retries. It then becomes a
// transparent pass-through between the Cheshire reg-out port and the slave.
//
// Optional feature macro: IGUANA_HYPER_INIT_VERIFY_EN. When defined, every
// successful write is read back from the same address and compared with the
// table data. A failed read-back counts as an error for that entry.
//
// Handshake: a master holds valid and every request field stable until the
// cycle in which ready = 1. The transfer completes in that cycle, and error
// and rdata are sampled in that same cycle.

package iguana_hyper_init_pkg;
  typedef struct packed {
    logic [47:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;
endpackage

module iguana_hyper_init_seq #(
  parameter type         reg_req_t            = iguana_hyper_init_pkg::reg_req_t,
  parameter type         reg_rsp_t            = iguana_hyper_init_pkg::reg_rsp_t,
  parameter int unsigned NumWrites            = 4,
  parameter logic [47:0] InitAddr [NumWrites] = '{48'h1_0000_0000, 48'h1_0000_0004,
                                                  48'h1_0000_0008, 48'h1_0000_000C},
  parameter logic [31:0] InitData [NumWrites] = '{32'h1, 32'h6, 32'h0, 32'h3},
  parameter int unsigned GapCycles            = 8,
  parameter int unsigned MaxRetries           = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  reg_req_t   slv_req_i,
  output reg_rsp_t   slv_rsp_o,
  output reg_req_t   mst_req_o,
  input  reg_rsp_t   mst_rsp_i,
  output logic       done_o,
  output logic       err_o,
  output logic [3:0] err_idx_o,
  output logic [2:0] dbg_state_o
);

  localparam int unsigned IdxW   = (NumWrites > 1) ? $clog2(NumWrites) : 1;
  localparam int unsigned RetryW = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_GAP    = 3'd2,
    ST_PASS   = 3'd3,
`ifdef IGUANA_HYPER_INIT_VERIFY_EN
    ST_VERIFY = 3'd5,
`endif
    ST_FAIL   = 3'd4
  } state_e;

  // After each attempt the sequencer waits in GAP, or goes straight back to
  // ISSUE when no gap is configured.
  localparam state_e StAfterAttempt = (GapCycles == 0) ? ST_ISSUE : ST_GAP;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic [7:0]        gap_q, gap_d;
  logic [3:0]        err_idx_q, err_idx_d;
  logic              entry_ok;
  logic              entry_err;

  // State and bookkeeping registers; reset restarts the table from entry 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_INIT;
      idx_q     <= '0;
      retry_q   <= '0;
      gap_q     <= '0;
      err_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      retry_q   <= retry_d;
      gap_q     <= gap_d;
      err_idx_q <= err_idx_d;
    end
  end

  // Next-state logic, request/response muxing and entry outcome resolution.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    retry_d   = retry_q;
    gap_d     = gap_q;
    err_idx_d = err_idx_q;
    entry_ok  = 1'b0;
    entry_err = 1'b0;
    mst_req_o = '0;
    slv_rsp_o = '0;

    case (state_q)
      ST_INIT: begin
        state_d = ST_ISSUE;
      end

      ST_ISSUE: begin
        mst_req_o.addr  = InitAddr[idx_q];
        mst_req_o.write = 1'b1;
        mst_req_o.wdata = InitData[idx_q];
        mst_req_o.wstrb = 4'hF;
        mst_req_o.valid = 1'b1;
        if (mst_rsp_i.ready) begin
          if (mst_rsp_i.error) begin
            entry_err = 1'b1;
          end else begin
`ifdef IGUANA_HYPER_INIT_VERIFY_EN
            state_d = ST_VERIFY;
`else
            entry_ok = 1'b1;
`endif
          end
        end
      end

`ifdef IGUANA_HYPER_INIT_VERIFY_EN
      ST_VERIFY: begin
        // Read back the address just written; write/wdata/wstrb stay zero.
        mst_req_o.addr  = InitAddr[idx_q];
        mst_req_o.valid = 1'b1;
        if (mst_rsp_i.ready) begin
          if (mst_rsp_i.error || (mst_rsp_i.rdata != InitData[idx_q])) begin
            entry_err = 1'b1;
          end else begin
            entry_ok = 1'b1;
          end
        end
      end
`endif

      ST_GAP: begin
        if ((32'(gap_q) + 32'd1) >= GapCycles) begin
          state_d = ST_ISSUE;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end

      ST_PASS, ST_FAIL: begin
        // Pass-through stays open after a failure so software can diagnose.
        mst_req_o = slv_req_i;
        slv_rsp_o = mst_rsp_i;
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase

    // Shared outcome handling for the write (and optional read-back).
    if (entry_ok) begin
      retry_d = '0;
      if (idx_q == IdxW'(NumWrites - 1)) begin
        state_d = ST_PASS;
      end else begin
        idx_d   = idx_q + IdxW'(1);
        gap_d   = '0;
        state_d = StAfterAttempt;
      end
    end else if (entry_err) begin
      if (32'(retry_q) < MaxRetries) begin
        retry_d = retry_q + RetryW'(1);
        gap_d   = '0;
        state_d = StAfterAttempt;
      end else begin
        err_idx_d = 4'(idx_q);
        state_d   = ST_FAIL;
      end
    end
  end

  // Status outputs follow the terminal states directly.
  always_comb begin
    done_o      = (state_q == ST_PASS) || (state_q == ST_FAIL);
    err_o       = (state_q == ST_FAIL);
    err_idx_o   = err_idx_q;
    dbg_state_o = state_q;
  end

endmodule

// File: tb/tb_iguana_hyper_init_seq.sv
// tb_iguana_hyper_init_seq: directed bench for the HyperBus init sequencer.
// Cycle 0 is the INIT cycle, i.e. the first cycle with rst_i low. A bench
// slave model answers the master port; every completed transfer is logged and
// compared against a hand-built expected queue.
// Build with IGUANA_HYPER_INIT_VERIFY_EN to run the read-back scenario.

module tb_iguana_hyper_init_seq;
  import iguana_hyper_init_pkg::*;

  localparam int W = 98;  // {error, write, cycle[15:0], addr[47:0], data[31:0]}
  localparam logic [47:0] A0 = 48'h1_0000_0000;
  localparam logic [47:0] A1 = 48'h1_0000_0004;
  localparam logic [47:0] A2 = 48'h1_0000_0008;
  localparam logic [47:0] A3 = 48'h1_0000_000C;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       rst_i;
  reg_req_t   slv_req;
  reg_rsp_t   slv_rsp;
  reg_req_t   mst_req;
  reg_rsp_t   mst_rsp;
  logic       done_o;
  logic       err_o;
  logic [3:0] err_idx_o;
  logic [2:0] dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  iguana_hyper_init_seq dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .slv_req_i   (slv_req),
    .slv_rsp_o   (slv_rsp),
    .mst_req_o   (mst_req),
    .mst_rsp_i   (mst_rsp),
    .done_o      (done_o),
    .err_o       (err_o),
    .err_idx_o   (err_idx_o),
    .dbg_state_o (dbg_state)
  );

  // ---------------- slave model ----------------
  int   wait_states    = 0;
  int   err_once_idx   = -1;
  int   err_always_idx = -1;
  int   bad_rd_idx     = -1;
  int   wait_cnt       = 0;
  logic err_once_used  = 1'b0;
  int   cyc            = 0;
  int   ent;

  logic [W-1:0] obs_q[$];
  logic [W-1:0] exp_q[$];
  int           log_rd = 0;

  function automatic logic [31:0] slave_data(input int e);
    case (e)
      0:       return 32'h1;
      1:       return 32'h6;
      2:       return 32'h0;
      3:       return 32'h3;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always_comb begin
    ent     = int'(mst_req.addr[5:2]);
    mst_rsp = '0;
    mst_rsp.ready = mst_req.valid && (wait_cnt >= wait_states);
    if (mst_rsp.ready) begin
      if (mst_req.write) begin
        if ((ent == err_always_idx) || ((ent == err_once_idx) && !err_once_used))
          mst_rsp.error = 1'b1;
      end else begin
        mst_rsp.rdata = (ent == bad_rd_idx) ? 32'd7 : slave_data(ent);
      end
    end
  end

  always @(posedge clk) begin
    cyc <= rst_i ? 0 : cyc + 1;
    if (mst_req.valid && !mst_rsp.ready) wait_cnt <= wait_cnt + 1;
    else                                 wait_cnt <= 0;
    if (rst_i && (dbg_state == 3'd0) && (cyc == 0) && !mst_req.valid)
      err_once_used <= err_once_used;
    if (mst_rsp.ready && mst_rsp.error && (ent == err_once_idx))
      err_once_used <= 1'b1;
    if (mst_req.valid && mst_rsp.ready)
      obs_q.push_back({mst_rsp.error, mst_req.write, 16'(cyc), mst_req.addr,
                       mst_req.write ? mst_req.wdata : mst_rsp.rdata});
  end

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic err, input logic wr, input int c,
                          input logic [47:0] addr, input logic [31:0] data);
    exp_q.push_back({err, wr, 16'(c), addr, data});
  endtask

  task automatic check_log(input string tag);
    int n_obs;
    int n;
    n_obs = obs_q.size() - log_rd;
    chk({tag, "_count"}, n_obs, exp_q.size());
    n = (n_obs < exp_q.size()) ? n_obs : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_%0d", tag, i), obs_q[log_rd + i], exp_q[i]);
    log_rd = obs_q.size();
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_slave(input int ws, input int once, input int always_e, input int bad_rd);
    wait_states    = ws;
    err_once_idx   = once;
    err_always_idx = always_e;
    bad_rd_idx     = bad_rd;
  endtask

  // Pulse reset for one edge; returns at the INIT cycle (cycle 0).
  task automatic start_seq();
    slv_req = '0;
    rst_i   = 1'b1;
    @(posedge clk);
    #1;
    rst_i   = 1'b0;
  endtask

  task automatic wait_to(input int c);
    int guard = 0;
    while ((cyc < c) && (guard < 2000)) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (cyc != c) chk("wait_timeout", cyc, c);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int hits;
    rst_i   = 1'b1;
    slv_req = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mst_req", mst_req, '0);
    chk("rst_slv_rsp", slv_rsp, '0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_err_idx", err_idx_o, 4'd0);

`ifndef IGUANA_HYPER_INIT_VERIFY_EN
    // Test 1: defaults, zero-wait error-free slave.
    set_slave(0, -1, -1, -1);
    start_seq();
    chk("t1_init_valid", mst_req.valid, 1'b0);
    wait_to(1);
    chk("t1_w0_ctl", {mst_req.valid, mst_req.write, mst_req.wstrb}, {1'b1, 1'b1, 4'hF});
    chk("t1_w0_addr", mst_req.addr, A0);
    wait_to(2);
    chk("t1_gap_req", mst_req, '0);
    wait_to(28);
    chk("t1_done_c28", done_o, 1'b0);
    wait_to(29);
    chk("t1_done_c29", done_o, 1'b1);
    chk("t1_err", err_o, 1'b0);
    push_exp(0, 1, 1,  A0, 32'h1);
    push_exp(0, 1, 10, A1, 32'h6);
    push_exp(0, 1, 19, A2, 32'h0);
    push_exp(0, 1, 28, A3, 32'h3);
    check_log("t1_log");

    // Test 2: one error on entry 2, retried after a full gap.
    set_slave(0, 2, -1, -1);
    start_seq();
    wait_to(37);
    chk("t2_done_c37", done_o, 1'b0);
    wait_to(38);
    chk("t2_done_c38", done_o, 1'b1);
    chk("t2_err", err_o, 1'b0);
    push_exp(0, 1, 1,  A0, 32'h1);
    push_exp(0, 1, 10, A1, 32'h6);
    push_exp(1, 1, 19, A2, 32'h0);
    push_exp(0, 1, 28, A2, 32'h0);
    push_exp(0, 1, 37, A3, 32'h3);
    check_log("t2_log");

    // Test 3: entry 1 always errors -> 4 attempts then FAIL; pass-through open.
    set_slave(0, -1, 1, -1);
    start_seq();
    wait_to(37);
    chk("t3_done_c37", done_o, 1'b0);
    wait_to(38);
    chk("t3_done_c38", done_o, 1'b1);
    chk("t3_err", err_o, 1'b1);
    chk("t3_err_idx", err_idx_o, 4'd1);
    wait_to(45);
    slv_req = '{addr: A0, write: 1'b0, wdata: 32'h0, wstrb: 4'h0, valid: 1'b1};
    #1;
    chk("t3_fail_rdy", slv_rsp.ready, 1'b1);
    chk("t3_fail_rdata", slv_rsp.rdata, 32'h1);
    wait_to(46);
    slv_req = '0;
    push_exp(0, 1, 1,  A0, 32'h1);
    push_exp(1, 1, 10, A1, 32'h6);
    push_exp(1, 1, 19, A1, 32'h6);
    push_exp(1, 1, 28, A1, 32'h6);
    push_exp(1, 1, 37, A1, 32'h6);
    push_exp(0, 0, 45, A0, 32'h1);
    check_log("t3_log");

    // Test 4: Cheshire write held from cycle 5 stalls until PASS.
    set_slave(0, -1, -1, -1);
    start_seq();
    wait_to(5);
    slv_req = '{addr: 48'h1_0000_0010, write: 1'b1, wdata: 32'hCAFE_0010,
                wstrb: 4'hF, valid: 1'b1};
    hits = 0;
    for (int c = 5; c < 29; c++) begin
      wait_to(c);
      if (slv_rsp.ready) hits++;
    end
    chk("t4_stall", hits, 0);
    wait_to(29);
    chk("t4_pt_addr", mst_req.addr, 48'h1_0000_0010);
    chk("t4_pt_valid", mst_req.valid, 1'b1);
    chk("t4_pt_ready", slv_rsp.ready, 1'b1);
    wait_to(30);
    slv_req = '{addr: A1, write: 1'b0, wdata: 32'h0, wstrb: 4'h0, valid: 1'b1};
    #1;
    chk("t4_rd_rdata", slv_rsp.rdata, 32'h6);
    wait_to(31);
    slv_req = '0;
    #1;
    chk("t4_idle_valid", mst_req.valid, 1'b0);
    push_exp(0, 1, 1,  A0, 32'h1);
    push_exp(0, 1, 10, A1, 32'h6);
    push_exp(0, 1, 19, A2, 32'h0);
    push_exp(0, 1, 28, A3, 32'h3);
    push_exp(0, 1, 29, 48'h1_0000_0010, 32'hCAFE_0010);
    push_exp(0, 0, 30, A1, 32'h6);
    check_log("t4_log");

    // Test 5: 3 wait states; reset mid-transfer of entry 1 restarts the table.
    set_slave(3, -1, -1, -1);
    start_seq();
    wait_to(14);
    chk("t5_mid_valid", mst_req.valid, 1'b1);
    chk("t5_mid_addr", mst_req.addr, A1);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    chk("t5_drop_valid", mst_req.valid, 1'b0);
    chk("t5_cycle0", cyc, 0);
    wait_to(40);
    chk("t5_done_c40", done_o, 1'b0);
    wait_to(41);
    chk("t5_done_c41", done_o, 1'b1);
    chk("t5_err", err_o, 1'b0);
    push_exp(0, 1, 4,  A0, 32'h1);
    push_exp(0, 1, 4,  A0, 32'h1);
    push_exp(0, 1, 16, A1, 32'h6);
    push_exp(0, 1, 28, A2, 32'h0);
    push_exp(0, 1, 40, A3, 32'h3);
    check_log("t5_log");
`else
    // Test 6: read-back after each write; entry 1 reads back 7.
    set_slave(0, -1, -1, 1);
    start_seq();
    wait_to(2);
    chk("t6_rd_ctl", {mst_req.valid, mst_req.write, mst_req.wstrb}, {1'b1, 1'b0, 4'h0});
    wait_to(42);
    chk("t6_done_c42", done_o, 1'b0);
    wait_to(43);
    chk("t6_done_c43", done_o, 1'b1);
    chk("t6_err", err_o, 1'b1);
    chk("t6_err_idx", err_idx_o, 4'd1);
    push_exp(0, 1, 1,  A0, 32'h1);
    push_exp(0, 0, 2,  A0, 32'h1);
    push_exp(0, 1, 11, A1, 32'h6);
    push_exp(0, 0, 12, A1, 32'h7);
    push_exp(0, 1, 21, A1, 32'h6);
    push_exp(0, 0, 22, A1, 32'h7);
    push_exp(0, 1, 31, A1, 32'h6);
    push_exp(0, 0, 32, A1, 32'h7);
    push_exp(0, 1, 41, A1, 32'h6);
    push_exp(0, 0, 42, A1, 32'h7);
    check_log("t6_log");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
